// File: rtl/bin_to_gray_pkg.sv
// Shared constants and width-masked binary/Gray conversion functions for bin_to_gray.
package bin_to_gray_pkg;

   localparam logic DIR_B2G = 1'b0;
   localparam logic DIR_G2B = 1'b1;
   localparam int unsigned MAX_WIDTH = 32;

   // Keeps only the low 'width' bits; a shift of 32 yields 0, so the mask becomes all ones.
   function automatic logic [MAX_WIDTH-1:0] width_mask(input int unsigned width);
      return (32'h1 << width) - 32'h1;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] b2g(input logic [MAX_WIDTH-1:0] word,
                                                input int unsigned        width);
      logic [MAX_WIDTH-1:0] w;
      w = word & width_mask(width);
      return w ^ (w >> 1);
   endfunction

   // XOR prefix from the MSB down; bits above 'width' are zero after masking.
   function automatic logic [MAX_WIDTH-1:0] g2b(input logic [MAX_WIDTH-1:0] word,
                                                input int unsigned        width);
      logic [MAX_WIDTH-1:0] g;
      logic [MAX_WIDTH-1:0] b;
      g = word & width_mask(width);
      b = '0;
      b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
      for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/bin_to_gray_popcnt1.sv
// Combinational "exactly one bit set" detector for the adjacency checker.
// Present only when BIN_TO_GRAY_ADJ_CHECK_EN is defined.
`ifdef BIN_TO_GRAY_ADJ_CHECK_EN
module bin_to_gray_popcnt1 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] word,
   output logic             one_c
);

   // Non-zero and clearing the lowest set bit leaves nothing.
   always_comb begin
      one_c = (word != '0) && ((word & (word - WIDTH'(1))) == '0);
   end

endmodule
`endif

// File: rtl/bin_to_gray.sv
// Registered binary<->Gray converter with one-cycle latency and valid qualifier.
// Optional macro BIN_TO_GRAY_ADJ_CHECK_EN adds adj_ok (Hamming distance 1 monitor).
module bin_to_gray
   import bin_to_gray_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             dir,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
`ifdef BIN_TO_GRAY_ADJ_CHECK_EN
   output logic             adj_ok,
`endif
   output logic             out_dir
);

   logic [WIDTH-1:0] conv_c;

   // Direction-selected conversion ahead of the output register.
   always_comb begin
      conv_c = '0;
      if (dir == DIR_G2B) begin
         conv_c = WIDTH'(g2b(MAX_WIDTH'(data_in), WIDTH));
      end else begin
         conv_c = WIDTH'(b2g(MAX_WIDTH'(data_in), WIDTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out  <= '0;
         out_dir   <= DIR_B2G;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            data_out <= conv_c;
            out_dir  <= dir;
         end
      end
   end

`ifdef BIN_TO_GRAY_ADJ_CHECK_EN
   logic [WIDTH-1:0] diff_c;
   logic             one_c;
   logic             seen;

   // data_out only updates on valid words, so it doubles as the previous-word register.
   always_comb begin
      diff_c = conv_c ^ data_out;
   end

   bin_to_gray_popcnt1 #(
      .WIDTH(WIDTH)
   ) u_popcnt1 (
      .word (diff_c),
      .one_c(one_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen   <= 1'b0;
         adj_ok <= 1'b0;
      end else if (in_valid) begin
         seen   <= 1'b1;
         adj_ok <= seen & one_c;
      end else begin
         adj_ok <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_bin_to_gray.sv
// Self-checking bench for bin_to_gray (WIDTH = 4): directed plan plus random stimulus
// against a table-driven reference; adj_ok checked when BIN_TO_GRAY_ADJ_CHECK_EN is defined.
module tb_bin_to_gray;

   localparam int unsigned WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             dir;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic             out_dir;
`ifdef BIN_TO_GRAY_ADJ_CHECK_EN
   logic             adj_ok;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reflected Gray sequence for 4 bits, indexed by binary value.
   logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   logic [3:0] exp_data;
   logic       exp_valid;
   logic       exp_dir;
   logic       exp_adj;
   logic       have_prev;

   bin_to_gray #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .dir      (dir),
      .data_in  (data_in),
      .data_out (data_out),
      .out_valid(out_valid),
`ifdef BIN_TO_GRAY_ADJ_CHECK_EN
      .adj_ok   (adj_ok),
`endif
      .out_dir  (out_dir)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [3:0] ref_conv(input logic d, input logic [3:0] x);
      logic [3:0] r;
      r = '0;
      if (d == 1'b0) r = gray_tbl[x];
      else begin
         for (int b = 0; b < 16; b++) if (gray_tbl[b] == x) r = 4'(b);
      end
      return r;
   endfunction

   task automatic model_reset();
      exp_data = '0; exp_valid = 1'b0; exp_dir = 1'b0; exp_adj = 1'b0; have_prev = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".data"},  32'(data_out),  32'(exp_data));
      check({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
      check({tag, ".dir"},   32'(out_dir),   32'(exp_dir));
`ifdef BIN_TO_GRAY_ADJ_CHECK_EN
      check({tag, ".adj"},   32'(adj_ok),    32'(exp_adj));
`endif
   endtask

   // Drive one cycle at the falling edge, then check at the next falling edge.
   task automatic step(input string tag, input logic v, input logic d, input logic [3:0] x);
      logic [3:0] w;
      in_valid = v; dir = d; data_in = x;
      @(negedge clk);
      if (v) begin
         w = ref_conv(d, x);
         exp_adj   = have_prev && ($countones(w ^ exp_data) == 1);
         have_prev = 1'b1;
         exp_data  = w;
         exp_dir   = d;
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
         exp_adj   = 1'b0;
      end
      check_outputs(tag);
   endtask

   task automatic do_reset();
      in_valid = 1'b1; dir = 1'b0; data_in = 4'hF;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; dir = 1'b0; data_in = '0;
      model_reset();
      do_reset();

      // Count 0..15 then wrap to 0 in binary->Gray.
      for (int i = 0; i < 16; i++) step("b2g", 1'b1, 1'b0, 4'(i));
      step("b2g_wrap", 1'b1, 1'b0, 4'h0);

      for (int i = 0; i < 16; i++) step("g2b", 1'b1, 1'b1, gray_tbl[i]);
      step("g2b_c", 1'b1, 1'b1, 4'hC);
      step("g2b_8", 1'b1, 1'b1, 4'h8);
      step("g2b_6", 1'b1, 1'b1, 4'h6);

      step("gap_word", 1'b1, 1'b0, 4'h5);
      for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 1'b1, 4'(i + 9));

      step("mix0", 1'b1, 1'b0, 4'hA);
      step("mix1", 1'b1, 1'b1, 4'hF);

      step("jump0", 1'b1, 1'b0, 4'h0);
      step("jump2", 1'b1, 1'b0, 4'h2);

      // Asynchronous reset mid-stream: outputs clear without a clock edge.
      step("pre_rst", 1'b1, 1'b1, 4'h7);
      in_valid = 1'b1; data_in = 4'h3;
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1'b1, 1'b0, 4'h1);

      for (int i = 0; i < 200; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
